// File: rtl/seg_pkg.sv
// seg_pkg: shared scan default, segment codes, control bytes, digit-entry type and hex helpers
package seg_pkg;
  localparam int SCAN_CNT_MAX_DEF = 50000;
  localparam logic [15:0][7:0] SEG_CODES = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] BYTE_BS  = 8'h08;
  localparam logic [7:0] BYTE_ESC = 8'h1B;
  localparam logic [7:0] BYTE_DOT = 8'h2E;
  localparam logic [7:0] BYTE_CR  = 8'h0D;
  localparam logic [7:0] BYTE_LF  = 8'h0A;
  typedef struct packed {
    logic       valid;
    logic [3:0] value;
    logic       dp;
  } digit_t;
  function automatic logic is_hex(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
  endfunction
  function automatic logic [3:0] hex_val(input logic [7:0] b);
    return b <= "9" ? b[3:0] : b[3:0] + 4'd9;
  endfunction
endpackage

// File: rtl/seg_decode.sv
// seg_decode: one digit entry (i_valid, i_value, i_dp) to active-low common-anode segments o_seg
module seg_decode
  import seg_pkg::*;
(
  input  logic       i_valid,
  input  logic [3:0] i_value,
  input  logic       i_dp,
  output logic [7:0] o_seg
);
  assign o_seg = {~i_dp, i_valid ? SEG_CODES[i_value][6:0] : SEG_BLANK};
endmodule

// File: rtl/uart_seg_disp.sv
// uart_seg_disp: UART bytes (pi_data/pi_flag) edit a 6-digit hex buffer scanned onto sel/seg; err_flag pulses on bad bytes
module uart_seg_disp
  import seg_pkg::*;
#(
  parameter int SCAN_CNT_MAX = SCAN_CNT_MAX_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic [5:0] sel,
  output logic [7:0] seg,
  output logic       err_flag
);
  localparam int CW = SCAN_CNT_MAX > 1 ? $clog2(SCAN_CNT_MAX) : 1;
  digit_t [5:0] r_buf;
  logic         r_err;
  logic [CW-1:0] r_cnt;
  logic [2:0]   r_idx;
  logic [5:0]   r_sel;
  logic [7:0]   r_seg;
  digit_t       w_cur;
  logic [7:0]   w_seg;
  logic         w_tc;
  assign w_cur = r_buf[r_idx];
  assign w_tc  = r_cnt == CW'(SCAN_CNT_MAX - 1);
  seg_decode u_dec (
    .i_valid(w_cur.valid),
    .i_value(w_cur.value),
    .i_dp   (w_cur.dp),
    .o_seg  (w_seg)
  );
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_buf <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (pi_flag) begin
        if (is_hex(pi_data))
          r_buf <= {r_buf[4:0], digit_t'{1'b1, hex_val(pi_data), 1'b0}};
        else if (pi_data == BYTE_DOT)
          r_buf[0].dp <= 1'b1;
        else if (pi_data == BYTE_BS)
          r_buf <= {digit_t'('0), r_buf[5:1]};
        else if (pi_data == BYTE_ESC)
          r_buf <= '0;
        else if (pi_data != BYTE_CR && pi_data != BYTE_LF)
          r_err <= 1'b1;
      end
    end
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
      r_sel <= 6'b111110;
      r_seg <= 8'hFF;
    end else begin
      r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
      r_idx <= w_tc ? (r_idx == 3'd5 ? 3'd0 : r_idx + 3'd1) : r_idx;
      r_sel <= ~(6'd1 << r_idx);
      r_seg <= w_seg;
    end
  end
  assign sel      = r_sel;
  assign seg      = r_seg;
  assign err_flag = r_err;
endmodule

// File: tb/tb_uart_seg_disp.sv
// tb_uart_seg_disp: table, directed and random checks of uart_seg_disp against a digit-list model
module tb_uart_seg_disp;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       pi_flag = 1'b0;
  logic [7:0] pi_data = 8'h00;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       err_flag;
  int vecs = 0;
  int errs = 0;
  int n = 0;
  int mv[6];
  bit md[6];
  logic [7:0] codes[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  typedef struct {
    logic       flag;
    logic [7:0] data;
    logic       err;
    int         dig;
    logic [7:0] seg;
  } vec_t;
  vec_t tbl[$];

  uart_seg_disp #(.SCAN_CNT_MAX(4)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pi_data  (pi_data),
    .pi_flag  (pi_flag),
    .sel      (sel),
    .seg      (seg),
    .err_flag (err_flag)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, n);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int v, input bit dp);
    logic [7:0] c;
    c = v < 0 ? 8'hFF : codes[v];
    return {~dp, c[6:0]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) begin
      mv[i] = -1;
      md[i] = 1'b0;
    end
  endfunction

  function automatic bit model_apply(input logic [7:0] b);
    int v;
    v = -1;
    if (b >= 8'h30 && b <= 8'h39) v = int'(b) - 48;
    else if (b >= 8'h41 && b <= 8'h46) v = int'(b) - 55;
    else if (b >= 8'h61 && b <= 8'h66) v = int'(b) - 87;
    if (v >= 0) begin
      for (int i = 5; i > 0; i--) begin
        mv[i] = mv[i-1];
        md[i] = md[i-1];
      end
      mv[0] = v;
      md[0] = 1'b0;
    end else if (b == 8'h2E) md[0] = 1'b1;
    else if (b == 8'h08) begin
      for (int i = 0; i < 5; i++) begin
        mv[i] = mv[i+1];
        md[i] = md[i+1];
      end
      mv[5] = -1;
      md[5] = 1'b0;
    end else if (b == 8'h1B) model_reset();
    else if (b != 8'h0D && b != 8'h0A) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic f, input logic [7:0] d);
    int sv[6];
    bit sd[6];
    int ix;
    bit bad;
    pi_flag = f;
    pi_data = d;
    @(posedge sys_clk);
    sv = mv;
    sd = md;
    bad = f ? model_apply(d) : 1'b0;
    n++;
    ix = ((n - 1) / 4) % 6;
    #1;
    chk("sel", {2'b00, sel}, {2'b00, ~(6'd1 << ix)});
    chk("seg", seg, exp_seg(sv[ix], sd[ix]));
    chk("err_flag", {7'd0, err_flag}, {7'd0, bad});
    pi_flag = 1'b0;
  endtask

  task automatic show(input int d, input logic [7:0] e, input string nm);
    logic [5:0] want;
    bit hit;
    want = ~(6'd1 << d);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step(1'b0, 8'h00);
      hit = sel == want;
    end
    if (!hit) begin
      vecs++;
      errs++;
      $display("FAIL %s: sel never reached %h", nm, want);
    end else chk(nm, seg, e);
  endtask

  function automatic logic [7:0] rand_byte();
    string hx;
    int r;
    hx = "0123456789abcdefABCDEF";
    r = $urandom_range(0, 19);
    if (r < 12) return hx[$urandom_range(0, 21)];
    if (r == 12) return 8'h2E;
    if (r == 13) return 8'h08;
    if (r == 14) return 8'h1B;
    if (r == 15) return 8'h0D;
    if (r == 16) return 8'h0A;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    model_reset();
    tbl.push_back('{1'b1, "1",   1'b0, 0, 8'hF9});
    tbl.push_back('{1'b1, "2",   1'b0, 0, 8'hA4});
    tbl.push_back('{1'b1, "3",   1'b0, 0, 8'hB0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1, 8'hA4});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 2, 8'hF9});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 3, 8'hFF});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 4, 8'hFF});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 5, 8'hFF});
    tbl.push_back('{1'b1, "7",   1'b0, 0, 8'hF8});
    tbl.push_back('{1'b1, "a",   1'b0, 0, 8'h88});
    tbl.push_back('{1'b1, ".",   1'b0, 0, 8'h08});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 4, 8'hF9});
    tbl.push_back('{1'b1, 8'h08, 1'b0, 0, 8'hF8});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 5, 8'hFF});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1, 8'hB0});
    tbl.push_back('{1'b1, 8'h1B, 1'b0, 0, 8'hFF});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 2, 8'hFF});
    tbl.push_back('{1'b1, ".",   1'b0, 0, 8'h7F});
    tbl.push_back('{1'b1, "A",   1'b0, 0, 8'h88});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1, 8'h7F});
    tbl.push_back('{1'b1, "Z",   1'b1, 0, 8'h88});
    tbl.push_back('{1'b1, 8'h0D, 1'b0, 0, 8'h88});
    tbl.push_back('{1'b1, 8'h0A, 1'b0, 0, 8'h88});
    tbl.push_back('{1'b1, "f",   1'b0, 0, 8'h8E});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1, 8'h88});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 2, 8'h7F});
    #1 sys_rst_n = 1'b0;
    #11;
    chk("rst_sel", {2'b00, sel}, 8'h3E);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_err", {7'd0, err_flag}, 8'h00);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 28; i++) step(1'b0, 8'h00);
    foreach (tbl[i]) begin
      if (tbl[i].flag) begin
        step(1'b1, tbl[i].data);
        chk($sformatf("tbl%0d_err", i), {7'd0, err_flag}, {7'd0, tbl[i].err});
      end
      show(tbl[i].dig, tbl[i].seg, $sformatf("tbl%0d_seg", i));
    end
    for (int c = 0; c < 8; c++) step(1'b1, 8'(8'h30 + c));
    show(5, 8'hA4, "b2b_d5");
    show(0, 8'hF8, "b2b_d0");
    show(2, 8'h92, "b2b_d2");
    step(1'b1, "Z");
    chk("z_pulse", {7'd0, err_flag}, 8'h01);
    step(1'b0, 8'h00);
    chk("z_pulse_end", {7'd0, err_flag}, 8'h00);
    show(0, 8'hF8, "z_nochange");
    #3;
    sys_rst_n = 1'b0;
    pi_flag = 1'b1;
    pi_data = "5";
    #1;
    chk("arst_sel", {2'b00, sel}, 8'h3E);
    chk("arst_seg", seg, 8'hFF);
    chk("arst_err", {7'd0, err_flag}, 8'h00);
    @(posedge sys_clk);
    #1;
    chk("hold_sel", {2'b00, sel}, 8'h3E);
    chk("hold_seg", seg, 8'hFF);
    pi_flag = 1'b0;
    #2;
    sys_rst_n = 1'b1;
    model_reset();
    n = 0;
    show(0, 8'hFF, "post_rst_d0");
    step(1'b1, "9");
    show(0, 8'h90, "post_rst_9");
    for (int i = 0; i < 400; i++) step($urandom_range(0, 2) != 0, rand_byte());
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
